// File: rtl/multi_cycle_controller_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// master: the controller (drives the control word, reads IR fields and status).
// slave:  the datapath (supplies IR fields, Zero and mem_ready, consumes controls).
//
// Signals:
//   opcode/funct  IR[31:26] / IR[5:0]
//   Zero          ALU zero flag
//   mem_ready     memory completes the current access this cycle
//   PCWrite .. ALU_Operation  datapath control word
//   illegal_op    one-cycle pulse on an unsupported instruction
//   mem_timeout   sticky memory-wait timeout flag
interface multi_cycle_controller_if #(
  parameter int OPW = 6
);
  logic [OPW-1:0] opcode;
  logic [OPW-1:0] funct;
  logic           Zero;
  logic           mem_ready;

  logic           PCWrite;
  logic           IorD;
  logic           MemRead;
  logic           MemWrite;
  logic           IRWrite;
  logic           RegDst;
  logic           MemtoReg;
  logic           RegWrite;
  logic           ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [1:0]     PCSrc;
  logic [2:0]     ALU_Operation;
  logic           illegal_op;
  logic           mem_timeout;

  modport master (
    input  opcode, funct, Zero, mem_ready,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALU_Operation, illegal_op,
           mem_timeout
  );

  modport slave (
    output opcode, funct, Zero, mem_ready,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALU_Operation, illegal_op,
           mem_timeout
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle MIPS datapath (fetch/decode/exec/mem/wb).
// Latency FETCH->FETCH: beq/j 3, R/addi/slti/sw 4, lw 5, illegal 2 (plus memory stalls).
// Stalls in FETCH/MEM_READ/MEM_WRITE until mem_ready; sticky mem_timeout after MAX_WAIT stalls.
//
// Ports:
//   clk   rising-edge system clock
//   rst   asynchronous active-high reset; all control outputs read 0 while high
//   bus   multi_cycle_controller_if.master (IR fields, Zero, mem_ready in;
//         datapath control word, illegal_op, mem_timeout out)
module multi_cycle_controller #(
  parameter int OPW      = 6,
  parameter int MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  multi_cycle_controller_if.master  bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);

  localparam logic [OPW-1:0] FN_ADD = OPW'(6'b100000);
  localparam logic [OPW-1:0] FN_SUB = OPW'(6'b100010);
  localparam logic [OPW-1:0] FN_AND = OPW'(6'b100100);
  localparam logic [OPW-1:0] FN_OR  = OPW'(6'b100101);
  localparam logic [OPW-1:0] FN_SLT = OPW'(6'b101010);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_timeout_q, mem_timeout_d;
  // lw/sw choice is captured in DECODE so MEM_ADDR does not depend on the IR.
  logic          is_lw_q, is_lw_d;

  logic          funct_ok;
  logic          op_legal;
  logic          mem_wait_state;
  logic          stalled;
  logic [2:0]    r_alu_op;

  // R-type funct decode: legality and ALU code.
  always_comb begin
    funct_ok = 1'b1;
    r_alu_op = ALU_ADD;
    case (bus.funct)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE:                               op_legal = funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_SLTI:                       op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  // Memory-wait bookkeeping: count stalled cycles in a waiting state,
  // saturate at MAX_WAIT, clear as soon as the access completes.
  assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                          (state_q == S_MEM_WRITE);
  assign stalled        = mem_wait_state && !bus.mem_ready;

  always_comb begin
    wait_cnt_d = '0;
    if (stalled) begin
      wait_cnt_d = (wait_cnt_q == CW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    mem_timeout_d = mem_timeout_q || (stalled && (wait_cnt_d == CW'(MAX_WAIT)));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        is_lw_d = (bus.opcode == OP_LW);
        state_d = S_FETCH;
        if (op_legal) begin
          case (bus.opcode)
            OP_LW, OP_SW:    state_d = S_MEM_ADDR;
            OP_RTYPE:        state_d = S_R_EXEC;
            OP_BEQ:          state_d = S_BRANCH;
            OP_J:            state_d = S_JUMP;
            OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
            default:         state_d = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR:  state_d = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      default:     state_d = S_FETCH;   // unreachable encodings recover
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      is_lw_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      is_lw_q       <= is_lw_d;
    end
  end

  // Control word. Decoded from the registered state; only the FETCH
  // handshake, the branch Zero and the opcode/funct-dependent ALU codes look
  // at inputs. Gated by rst so a reset mid-instruction kills writes at once.
  always_comb begin
    bus.PCWrite       = 1'b0;
    bus.IorD          = 1'b0;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegDst        = 1'b0;
    bus.MemtoReg      = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.ALUSrcA       = 1'b0;
    bus.ALUSrcB       = 2'b00;
    bus.PCSrc         = 2'b00;
    bus.ALU_Operation = 3'b000;
    bus.illegal_op    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.MemRead       = 1'b1;
          bus.ALUSrcB       = 2'b01;
          bus.ALU_Operation = ALU_ADD;
          bus.IRWrite       = bus.mem_ready;
          bus.PCWrite       = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcB       = 2'b11;
          bus.ALU_Operation = ALU_ADD;
          bus.illegal_op    = !op_legal;
        end
        S_MEM_ADDR: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALUSrcB       = 2'b10;
          bus.ALU_Operation = ALU_ADD;
        end
        S_MEM_READ: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_MEM_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        S_MEM_WRITE: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        S_R_EXEC: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALU_Operation = r_alu_op;
        end
        S_R_WB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALU_Operation = ALU_SUB;
          bus.PCSrc         = 2'b01;
          bus.PCWrite       = bus.Zero;
        end
        S_JUMP: begin
          bus.PCWrite = 1'b1;
          bus.PCSrc   = 2'b10;
        end
        S_I_EXEC: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALUSrcB       = 2'b10;
          bus.ALU_Operation = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_I_WB: begin
          bus.RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_timeout = mem_timeout_q;

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback steps.
- Drives the 3-bit ALU operation code directly: 000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT.
- Stalls on a memory-ready handshake and resolves beq from the ALU Zero flag.

Parameters:
- OPW, 6, opcode and funct field width.
- MAX_WAIT, 15, memory-wait cycle limit before mem_timeout is flagged.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC load enable (unconditional, or conditional branch already resolved).
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  1 = rd, 0 = rt.
- MemtoReg  out  1  1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm shifted left 2.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALU_Operation  out  3  code to ALU.
- illegal_op  out  1  one-cycle pulse on an unsupported instruction.
- mem_timeout  out  1  sticky flag; cleared only by reset.

Behaviour:
- Reset:
  - rst high: state = FETCH, wait counter = 0, mem_timeout = 0.
  - All outputs are forced 0 while rst is high.
  - Reset mid-instruction abandons it; no partial writes are issued after rst rises.
- Outputs are decoded from state, plus mem_ready/Zero/opcode/funct where stated. All unlisted outputs are 0.
- Supported opcodes:
  - R-type 000000.
  - lw 100011, sw 101011.
  - beq 000100, j 000010.
  - addi 001000, slti 001010.
- R-type funct to ALU_Operation:
  - add 100000 -> 010; sub 100010 -> 011.
  - and 100100 -> 000; or 100101 -> 001.
  - slt 101010 -> 111.
- States and outputs:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_Operation=010, PCSrc=00.
    - IRWrite=PCWrite=mem_ready.
    - Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALU_Operation=010 (branch target to ALUOut). Next state:
    - lw/sw -> MEM_ADDR.
    - R-type with legal funct -> R_EXEC.
    - beq -> BRANCH.
    - j -> JUMP.
    - addi/slti -> I_EXEC.
    - anything else -> FETCH, with illegal_op=1 for that cycle.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_Operation=010. lw -> MEM_READ; sw -> MEM_WRITE.
  - MEM_READ: MemRead=1, IorD=1. Hold until mem_ready, then -> MEM_WB.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1. Hold until mem_ready, then -> FETCH.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALU_Operation from funct -> R_WB.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_Operation=011, PCSrc=01, PCWrite=Zero -> FETCH.
  - JUMP: PCWrite=1, PCSrc=10 -> FETCH.
  - I_EXEC: ALUSrcA=1, ALUSrcB=10. ALU_Operation = 010 for addi, 111 for slti -> I_WB.
  - I_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Memory handshake:
  - MemRead/MemWrite stay held stable while waiting.
  - The wait counter increments each stalled cycle (FETCH, MEM_READ, MEM_WRITE) and clears on leaving the state.
  - When it reaches MAX_WAIT, mem_timeout sets and stays set. The FSM keeps waiting; mem_timeout is never auto-cleared.
  - The counter saturates at MAX_WAIT; it does not wrap.
- opcode/funct are sampled only in DECODE and R_EXEC/I_EXEC. IR is stable there because IRWrite=0.
- Latency with mem_ready=1 always, counted FETCH to next FETCH:
  - beq/j: 3 cycles.
  - R-type/addi/slti/sw: 4 cycles.
  - lw: 5 cycles.
  - Illegal instruction: 2 cycles.
- Unreachable state encodings -> FETCH on the next clock.

Test Plan:
- Reset with rst=1 for 2 cycles, then release with mem_ready=1 -> all outputs 0 during reset; first cycle after release has MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01, ALU_Operation=010.
- R-type sub (opcode 000000, funct 100010), mem_ready=1 -> R_EXEC shows ALU_Operation=011, ALUSrcA=1, ALUSrcB=00; next cycle RegWrite=1, RegDst=1; back in FETCH after 4 cycles. Repeat for slt -> ALU_Operation=111.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ -> MemRead=1, IorD=1 held 4 cycles; MEM_WB RegWrite=1, MemtoReg=1; total 8 cycles.
- beq (000100) with Zero=1 -> PCWrite=1, PCSrc=01, ALU_Operation=011 in BRANCH. With Zero=0 -> PCWrite=0; both take 3 cycles.
- Opcode 111111 -> illegal_op pulses for exactly 1 cycle in DECODE, then FETCH; no RegWrite/MemWrite asserted.
- mem_ready held 0 in FETCH for 16 cycles -> mem_timeout=1 from cycle 16 and stays set. Asserting rst mid-MEM_WRITE -> MemWrite drops immediately and the FSM restarts at FETCH.
